mem_port_arbiter: RTL and testbench

- Shares one 64-bit unified memory port between the pipeline's instruction-fetch requester (I) and data-access requester (D).
- Sits between the IF/MEM stages and the backing memory. Serialises accesses, latches request state and returns registered acks that the stages use as stall-release.
- Provides D-priority arbitration with an anti-starvation guarantee for I, halt draining, and a bus timeout.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/arb_timeout_ctr.sv | 50 +++++
 rtl/mem_port_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory-port arbiter.
//   arb_state_e : arbiter FSM states (IDLE, BUSY_I, BUSY_D)
//   port_sel_e  : identifies which requester owns the current access
//   cnt_width   : number of bits needed to hold a counter value 0..maxVal
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    SEL_I = 1'b0,
    SEL_D = 1'b1
  } port_sel_e;

  function automatic int cnt_width(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/arb_timeout_ctr.sv
// Bus-timeout counter for the memory-port arbiter.
// Cleared when an access is granted, advanced on every BUSY cycle that
// sees no backing-memory ack, and flags expiry on the LIMIT-th such cycle.
// Ports:
//   clk_i    : clock
//   reset_i  : synchronous active-high reset
//   load_i   : restart the count at zero (access granted)
//   en_i     : a BUSY cycle without m_ack
//   expire_o : this cycle is the LIMIT-th unanswered BUSY cycle
module arb_timeout_ctr
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = cnt_width(LIMIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);
  localparam logic [CNT_W-1:0] TOP  = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count holds the number of unanswered BUSY cycles already elapsed, so
  // the cycle that brings it to LIMIT is the one seeing cnt_q == LIMIT-1.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != TOP)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit backing-memory port between instruction fetch (I) and
// data access (D). D has priority, but after MAX_D_STREAK consecutive D
// grants with a fetch waiting, I is forced through. Acks are registered
// one-cycle pulses; a BUSY access with no m_ack for TIMEOUT cycles is
// aborted with zero read data and a sticky bus_err.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   i_req/i_addr/i_rdata/i_ack : fetch requester (32-bit word return)
//   d_req/d_we/d_addr/d_wdata/d_rdata/d_ack : data requester (64-bit)
//   halt/halted                : stop granting I / arbiter quiescent
//   m_req/m_we/m_addr/m_wdata/m_rdata/m_ack : backing-memory port
//   bus_err                    : sticky timeout flag
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [63:0]       d_wdata,
  output logic [63:0]       d_rdata,
  output logic              d_ack,
  input  logic              halt,
  output logic              halted,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [63:0]       m_wdata,
  input  logic [63:0]       m_rdata,
  input  logic              m_ack,
  output logic              bus_err
);

  localparam int STREAK_W = cnt_width(MAX_D_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  arb_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [63:0]         wdata_q, wdata_d;
  logic                fetchHi_q, fetchHi_d;
  logic                iAck_q, iAck_d;
  logic                dAck_q, dAck_d;
  logic [31:0]         iRdata_q, iRdata_d;
  logic [63:0]         dRdata_q, dRdata_d;
  logic                busErr_q, busErr_d;
  logic [STREAK_W-1:0] streak_q, streak_d;

  logic      busy;
  logic      iEligible;
  logic      dEligible;
  logic      grantD;
  logic      grantI;
  logic      toExpire;
  port_sel_e activeSel;
  logic      unusedAddrBits;

  // Byte-offset bits below the doubleword are dropped when latching the
  // address; i_addr[2] is kept separately to pick the fetched word.
  assign unusedAddrBits = ^{i_addr[1:0], d_addr[2:0]};

  assign busy = (state_q != IDLE);

  // A requester whose ack is still showing has not yet had a chance to drop
  // its request, so it must not be granted again in that cycle.
  assign iEligible = i_req && !iAck_q && !halt;
  assign dEligible = d_req && !dAck_q;
  assign grantD    = (state_q == IDLE) && dEligible &&
                     (!iEligible || (streak_q != STREAK_MAX));
  assign grantI    = (state_q == IDLE) && iEligible && !grantD;
  assign activeSel = (state_q == BUSY_D) ? SEL_D : SEL_I;

  arb_timeout_ctr #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk_i    (clk),
    .reset_i  (reset),
    .load_i   (grantD || grantI),
    .en_i     (busy && !m_ack),
    .expire_o (toExpire)
  );

  // Next-state logic: IDLE arbitrates and latches the winner's request;
  // BUSY waits for m_ack (or timeout) and returns data with a one-cycle ack.
  // A timeout completes like a normal access but with zero data and the
  // sticky error set; an m_ack in the expiry cycle takes precedence.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    fetchHi_d = fetchHi_q;
    iAck_d    = 1'b0;
    dAck_d    = 1'b0;
    iRdata_d  = iRdata_q;
    dRdata_d  = dRdata_q;
    busErr_d  = busErr_q;
    streak_d  = i_req ? streak_q : '0;

    case (state_q)
      IDLE: begin
        if (grantD) begin
          state_d = BUSY_D;
          addr_d  = {d_addr[ADDR_W-1:3], 3'b000};
          we_d    = d_we;
          wdata_d = d_wdata;
          if (i_req && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
          end
        end else if (grantI) begin
          state_d   = BUSY_I;
          addr_d    = {i_addr[ADDR_W-1:3], 3'b000};
          we_d      = 1'b0;
          wdata_d   = '0;
          fetchHi_d = i_addr[2];
          streak_d  = '0;
        end
      end

      BUSY_I, BUSY_D: begin
        if (m_ack || toExpire) begin
          state_d = IDLE;
          if (activeSel == SEL_D) begin
            dAck_d   = 1'b1;
            dRdata_d = (m_ack && !we_q) ? m_rdata : 64'd0;
          end else begin
            iAck_d   = 1'b1;
            iRdata_d = !m_ack    ? 32'd0 :
                       fetchHi_q ? m_rdata[63:32] : m_rdata[31:0];
          end
          if (!m_ack) begin
            busErr_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset aborts any in-flight access without an ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      fetchHi_q <= 1'b0;
      iAck_q    <= 1'b0;
      dAck_q    <= 1'b0;
      iRdata_q  <= '0;
      dRdata_q  <= '0;
      busErr_q  <= 1'b0;
      streak_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      fetchHi_q <= fetchHi_d;
      iAck_q    <= iAck_d;
      dAck_q    <= dAck_d;
      iRdata_q  <= iRdata_d;
      dRdata_q  <= dRdata_d;
      busErr_q  <= busErr_d;
      streak_q  <= streak_d;
    end
  end

  // halted drops as soon as a D grant is being taken out of IDLE.
  assign halted  = (state_q == IDLE) && halt && !grantD;
  assign m_req   = busy;
  assign m_we    = we_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign i_ack   = iAck_q;
  assign d_ack   = dAck_q;
  assign i_rdata = iRdata_q;
  assign d_rdata = dRdata_q;
  assign bus_err = busErr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one task per scenario with inline
// comparisons against hand-computed values.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [63:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic [63:0] d_rdata;
  logic        d_ack;
  logic        halt;
  logic        halted;
  logic        m_req;
  logic        m_we;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [63:0] m_rdata;
  logic        m_ack;
  logic        bus_err;

  logic        memAuto   = 1'b1;
  int          memLat    = 0;
  logic        forceAck  = 1'b0;
  logic        autoAck   = 1'b0;
  int          busyCnt   = 0;
  logic        prevReq   = 1'b0;
  logic [63:0] grantLog[$];
  int          iAckCnt   = 0;
  int          dAckCnt   = 0;
  int          nCompared   = 0;
  int          nMismatched = 0;

  mem_port_arbiter #(
    .ADDR_W       (64),
    .MAX_D_STREAK (4),
    .TIMEOUT      (255)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_ack   (i_ack),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_ack   (d_ack),
    .halt    (halt),
    .halted  (halted),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ack   (m_ack),
    .bus_err (bus_err)
  );

  always #5 clk = ~clk;

  // Backing memory answers on the (memLat+1)-th cycle of each access when
  // in auto mode; otherwise the scenario drives m_ack directly.
  assign m_ack = memAuto ? autoAck : forceAck;

  // Mid-cycle observer: memory latency model, grant log (address at the
  // first cycle of every access) and ack pulse counters.
  always @(negedge clk) begin
    if (m_req) begin
      autoAck = (busyCnt >= memLat);
      busyCnt++;
    end else begin
      autoAck = 1'b0;
      busyCnt = 0;
    end
    if (m_req && !prevReq) grantLog.push_back(m_addr);
    prevReq = m_req;
    if (i_ack) iAckCnt++;
    if (d_ack) dAckCnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; halt = 1'b0; m_rdata = '0;
    tick(); tick();
    nCompared++;
    if ({i_ack, d_ack, i_rdata, d_rdata, bus_err, halted} !== '0) begin
      nMismatched++;
      $display("[TB] FAIL reset_acks_data: got %h expected 0",
               {i_ack, d_ack, i_rdata, d_rdata, bus_err, halted});
    end
    nCompared++;
    if ({m_req, m_we, m_addr, m_wdata} !== '0) begin
      nMismatched++;
      $display("[TB] FAIL reset_mport: got %h expected 0", {m_req, m_we, m_addr, m_wdata});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_fetch();
    int g0 = grantLog.size();
    int a0 = iAckCnt;
    memAuto = 1'b1; memLat = 0;
    m_rdata = 64'hAAAA_BBBB_1111_2222;
    i_req = 1'b1; i_addr = 64'h104;
    tick();
    nCompared++;
    if ({m_req, m_we, i_ack} !== 3'b100) begin
      nMismatched++;
      $display("[TB] FAIL fetch_busy: got req/we/ack %b expected 100", {m_req, m_we, i_ack});
    end
    nCompared++;
    if (m_addr !== 64'h100) begin
      nMismatched++;
      $display("[TB] FAIL fetch_maddr: got %h expected 100", m_addr);
    end
    tick();
    nCompared++;
    if (i_ack !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL fetch_ack: got %b expected 1", i_ack);
    end
    nCompared++;
    if (i_rdata !== 32'hAAAABBBB) begin
      nMismatched++;
      $display("[TB] FAIL fetch_rdata: got %h expected aaaabbbb", i_rdata);
    end
    tick();
    nCompared++;
    if ({i_ack, m_req} !== 2'b00) begin
      nMismatched++;
      $display("[TB] FAIL fetch_no_regrant: got ack/req %b expected 00", {i_ack, m_req});
    end
    i_req = 1'b0;
    tick();
    nCompared++;
    if ((grantLog.size() - g0) != 1 || (iAckCnt - a0) != 1) begin
      nMismatched++;
      $display("[TB] FAIL fetch_counts: got grants %0d acks %0d expected 1 1",
               grantLog.size() - g0, iAckCnt - a0);
    end
  endtask

  task automatic test_d_write();
    int g0 = grantLog.size();
    int a0 = dAckCnt;
    memAuto = 1'b1; memLat = 2;
    m_rdata = 64'h0000_0000_0000_1234;
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h208; d_wdata = 64'hDEAD_BEEF_0000_0001;
    for (int c = 1; c <= 3; c++) begin
      tick();
      nCompared++;
      if ({m_req, m_we, m_addr, m_wdata, d_ack} !== {2'b11, 64'h208, 64'hDEAD_BEEF_0000_0001, 1'b0}) begin
        nMismatched++;
        $display("[TB] FAIL dwr_busy_c%0d: got req %b we %b addr %h wdata %h ack %b", c,
                 m_req, m_we, m_addr, m_wdata, d_ack);
      end
    end
    tick();
    nCompared++;
    if ({d_ack, m_req, d_rdata} !== {2'b10, 64'd0}) begin
      nMismatched++;
      $display("[TB] FAIL dwr_ack: got ack %b req %b rdata %h expected 1 0 0", d_ack, m_req, d_rdata);
    end
    d_req = 1'b0; d_we = 1'b0;
    tick();
    nCompared++;
    if ({d_ack, m_req} !== 2'b00) begin
      nMismatched++;
      $display("[TB] FAIL dwr_after: got ack/req %b expected 00", {d_ack, m_req});
    end
    nCompared++;
    if ((grantLog.size() - g0) != 1 || (dAckCnt - a0) != 1) begin
      nMismatched++;
      $display("[TB] FAIL dwr_counts: got grants %0d acks %0d expected 1 1",
               grantLog.size() - g0, dAckCnt - a0);
    end
  endtask

  task automatic test_back_to_back();
    memAuto = 1'b1; memLat = 0;
    m_rdata = 64'h0123_4567_89AB_CDEF;
    i_req = 1'b1; i_addr = 64'h80;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h40;
    tick();
    nCompared++;
    if ({m_req, m_addr} !== {1'b1, 64'h40}) begin
      nMismatched++;
      $display("[TB] FAIL b2b_d_first: got req %b addr %h expected 1 40", m_req, m_addr);
    end
    tick();
    nCompared++;
    if ({d_ack, d_rdata} !== {1'b1, 64'h0123_4567_89AB_CDEF}) begin
      nMismatched++;
      $display("[TB] FAIL b2b_d_ack: got ack %b rdata %h", d_ack, d_rdata);
    end
    d_req = 1'b0;
    tick();
    nCompared++;
    if ({m_req, m_addr, d_ack} !== {1'b1, 64'h80, 1'b0}) begin
      nMismatched++;
      $display("[TB] FAIL b2b_i_granted: got req %b addr %h dack %b expected 1 80 0", m_req, m_addr, d_ack);
    end
    tick();
    nCompared++;
    if ({i_ack, i_rdata} !== {1'b1, 32'h89AB_CDEF}) begin
      nMismatched++;
      $display("[TB] FAIL b2b_i_ack: got ack %b rdata %h expected 1 89abcdef", i_ack, i_rdata);
    end
    i_req = 1'b0;
    tick();
  endtask

  // Both requests stay up. halt is lowered only in IDLE cycles that carry no
  // ack, so those are the only cycles where I and D compete; the ack cycles
  // then show plain alternation rules. Expected D,D,D,D,I,D,D,D,D,I.
  task automatic test_streak();
    logic [63:0] expOrder [10];
    int guard = 0;
    expOrder[0] = 64'h600; expOrder[1] = 64'h600; expOrder[2] = 64'h600;
    expOrder[3] = 64'h600; expOrder[4] = 64'h500; expOrder[5] = 64'h600;
    expOrder[6] = 64'h600; expOrder[7] = 64'h600; expOrder[8] = 64'h600;
    expOrder[9] = 64'h500;
    memAuto = 1'b1; memLat = 0;
    grantLog.delete();
    i_req = 1'b1; i_addr = 64'h500;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h600;
    while (grantLog.size() < 10 && guard < 200) begin
      halt = !(!m_req && !i_ack && !d_ack);
      tick();
      guard++;
    end
    i_req = 1'b0; d_req = 1'b0; halt = 1'b0;
    repeat (4) tick();
    nCompared++;
    if (grantLog.size() != 10) begin
      nMismatched++;
      $display("[TB] FAIL streak_count: got %0d grants expected 10", grantLog.size());
    end
    for (int k = 0; k < 10 && k < grantLog.size(); k++) begin
      nCompared++;
      if (grantLog[k] !== expOrder[k]) begin
        nMismatched++;
        $display("[TB] FAIL streak_order[%0d]: got %h expected %h", k, grantLog[k], expOrder[k]);
      end
    end
  endtask

  task automatic test_halt();
    memAuto = 1'b1; memLat = 1;
    m_rdata = 64'h1111_2222_3333_4444;
    i_req = 1'b1; i_addr = 64'h700; halt = 1'b0;
    tick();
    halt = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h800;
    nCompared++;
    if ({m_req, m_addr, halted} !== {1'b1, 64'h700, 1'b0}) begin
      nMismatched++;
      $display("[TB] FAIL halt_busy_i: got req %b addr %h halted %b", m_req, m_addr, halted);
    end
    tick(); tick();
    nCompared++;
    if ({i_ack, i_rdata} !== {1'b1, 32'h3333_4444}) begin
      nMismatched++;
      $display("[TB] FAIL halt_i_done: got ack %b rdata %h expected 1 33334444", i_ack, i_rdata);
    end
    tick();
    nCompared++;
    if ({m_req, m_addr, halted} !== {1'b1, 64'h800, 1'b0}) begin
      nMismatched++;
      $display("[TB] FAIL halt_d_granted: got req %b addr %h halted %b", m_req, m_addr, halted);
    end
    tick(); tick();
    nCompared++;
    if ({d_ack, d_rdata} !== {1'b1, 64'h1111_2222_3333_4444}) begin
      nMismatched++;
      $display("[TB] FAIL halt_d_done: got ack %b rdata %h", d_ack, d_rdata);
    end
    d_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      nCompared++;
      if ({halted, m_req} !== 2'b10) begin
        nMismatched++;
        $display("[TB] FAIL halt_held_%0d: got halted/req %b expected 10", c, {halted, m_req});
      end
    end
    halt = 1'b0;
    tick();
    nCompared++;
    if ({m_req, m_addr, halted} !== {1'b1, 64'h700, 1'b0}) begin
      nMismatched++;
      $display("[TB] FAIL halt_release: got req %b addr %h halted %b", m_req, m_addr, halted);
    end
    tick(); tick();
    i_req = 1'b0;
    tick();
  endtask

  task automatic run_d_read_until_ack(input logic [63:0] addr, output int busyCycles);
    int guard = 0;
    busyCycles = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = addr;
    while (guard < 400) begin
      tick();
      guard++;
      if (d_ack) break;
      if (m_req) busyCycles++;
    end
  endtask

  task automatic test_timeout();
    int busyCycles;
    memAuto = 1'b0; forceAck = 1'b0;
    m_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    run_d_read_until_ack(64'h900, busyCycles);
    nCompared++;
    if (busyCycles != 255 || d_ack !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL tmo_cycles: got %0d busy cycles ack %b expected 255 1", busyCycles, d_ack);
    end
    nCompared++;
    if ({d_rdata, bus_err} !== {64'd0, 1'b1}) begin
      nMismatched++;
      $display("[TB] FAIL tmo_result: got rdata %h err %b expected 0 1", d_rdata, bus_err);
    end
    d_req = 1'b0;
    memAuto = 1'b1; memLat = 0;
    i_req = 1'b1; i_addr = 64'h10;
    tick(); tick();
    i_req = 1'b0;
    tick();
    nCompared++;
    if (bus_err !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL tmo_sticky: got %b expected 1", bus_err);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    nCompared++;
    if (bus_err !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL tmo_cleared: got %b expected 0", bus_err);
    end
  endtask

  task automatic test_timeout_race();
    int busyCycles;
    memAuto = 1'b1; memLat = 254;
    m_rdata = 64'h0BAD_F00D_CAFE_0001;
    run_d_read_until_ack(64'h910, busyCycles);
    nCompared++;
    if (busyCycles != 255 || d_ack !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL race_cycles: got %0d busy cycles ack %b expected 255 1", busyCycles, d_ack);
    end
    nCompared++;
    if ({d_rdata, bus_err} !== {64'h0BAD_F00D_CAFE_0001, 1'b0}) begin
      nMismatched++;
      $display("[TB] FAIL race_result: got rdata %h err %b expected 0badf00dcafe0001 0", d_rdata, bus_err);
    end
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    int a0 = dAckCnt;
    memAuto = 1'b0; forceAck = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'hA08; d_wdata = 64'h55;
    tick(); tick();
    nCompared++;
    if ({m_req, m_addr} !== {1'b1, 64'hA08}) begin
      nMismatched++;
      $display("[TB] FAIL rst_mid_busy: got req %b addr %h expected 1 a08", m_req, m_addr);
    end
    reset = 1'b1; d_req = 1'b0; d_we = 1'b0;
    tick();
    reset = 1'b0; forceAck = 1'b1;
    nCompared++;
    if ({m_req, m_we, m_addr, m_wdata, d_ack, d_rdata, bus_err} !== '0) begin
      nMismatched++;
      $display("[TB] FAIL rst_mid_outputs: got req %b we %b addr %h wdata %h ack %b err %b",
               m_req, m_we, m_addr, m_wdata, d_ack, bus_err);
    end
    tick();
    forceAck = 1'b0;
    repeat (3) tick();
    nCompared++;
    if ({m_req, d_ack, d_rdata} !== '0 || (dAckCnt - a0) != 0) begin
      nMismatched++;
      $display("[TB] FAIL rst_late_ack: got req %b ack %b acks seen %0d expected 0 0 0",
               m_req, d_ack, dAckCnt - a0);
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_d_write();
    test_back_to_back();
    test_streak();
    test_halt();
    test_timeout();
    test_timeout_race();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
